// File: rtl/serial_to_par_rx.sv
// Serial-to-parallel lane receiver: hunts for the IDLE comma at any bit offset,
// locks the byte boundary after LOCK_CNT aligned IDLE bytes, then emits one byte per 8 clocks.
module serial_to_par_rx #(
    parameter logic [7:0]  IDLE     = 8'hBC,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned IDLE_W = 4;
    localparam logic [IDLE_W-1:0] LP_LOCK = IDLE_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              r_state;
    logic [BYTE_W-1:0]   r_sr;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [IDLE_W-1:0]   r_idle_cnt;

    logic [BYTE_W-1:0]   w_nxt;
    logic                w_is_idle;
    logic                w_boundary;

    // Shift-register contents after this edge's sample; boundary = last bit of a byte.
    assign w_nxt      = {r_sr[BYTE_W-2:0], data_in};
    assign w_is_idle  = (w_nxt == IDLE);
    assign w_boundary = (r_bit_cnt == CNT_W'(7));

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            r_state     <= HUNT;
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_idle_cnt  <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            r_sr        <= w_nxt;
            byte_strobe <= 1'b0;
            case (r_state)
                HUNT: begin
                    if (w_is_idle) begin
                        r_state    <= ALIGN;
                        r_bit_cnt  <= '0;
                        r_idle_cnt <= IDLE_W'(1);
                    end
                end
                ALIGN: begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (w_boundary) begin
                        if (w_is_idle) begin
                            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                            // Lock edge itself does not strobe; first byte comes 8 edges later.
                            if ((r_idle_cnt + IDLE_W'(1)) == LP_LOCK) begin
                                r_state <= LOCKED;
                                active  <= 1'b1;
                            end
                        end else begin
                            r_state    <= HUNT;
                            r_idle_cnt <= '0;
                        end
                    end
                end
                LOCKED: begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (w_boundary) begin
                        data_out    <= w_nxt;
                        valid_out   <= ~w_is_idle;
                        byte_strobe <= 1'b1;
                    end
                end
                default: begin
                    r_state <= HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_to_par_rx.sv
// Directed bench for serial_to_par_rx: reset, offset lock, delivery, abort, mid-byte reset, loopback.
module tb_serial_to_par_rx;

    localparam logic [7:0] IDLE = 8'hBC;

    logic       clk_8f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt;
    int first_active;
    int strobe_cnt;
    logic [7:0] exp_prev;
    logic       exp_prev_v;

    serial_to_par_rx #(.IDLE(8'hBC), .LOCK_CNT(4)) dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    initial begin
        clk_8f = 1'b0;
        forever #5 clk_8f = ~clk_8f;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_track();
        edge_cnt     = 0;
        first_active = -1;
        strobe_cnt   = 0;
    endtask

    // Drive one bit, advance one edge, sample just after it.
    task automatic tick(input logic b);
        data_in = b;
        @(posedge clk_8f);
        #1;
        edge_cnt++;
        if (active === 1'b1 && first_active < 0) first_active = edge_cnt;
        if (byte_strobe === 1'b1) strobe_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tick(b[i]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"},   32'(data_out),    32'h0);
        check({tag, "_valid"},  32'(valid_out),   32'h0);
        check({tag, "_strobe"}, 32'(byte_strobe), 32'h0);
        check({tag, "_active"}, 32'(active),      32'h0);
    endtask

    // Send a byte while locked; previous output must hold for 7 edges, then update with a strobe.
    task automatic rx_byte_locked(input logic [7:0] b, input string tag);
        int bad;
        bad = 0;
        for (int i = 7; i >= 1; i--) begin
            tick(b[i]);
            if (byte_strobe !== 1'b0 || data_out !== exp_prev || valid_out !== exp_prev_v) bad++;
        end
        tick(b[0]);
        check({tag, "_hold"},   32'(bad),         32'd0);
        check({tag, "_data"},   32'(data_out),    32'(b));
        check({tag, "_valid"},  32'(valid_out),   32'(b != IDLE));
        check({tag, "_strobe"}, 32'(byte_strobe), 32'd1);
        exp_prev   = b;
        exp_prev_v = (b != IDLE);
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 1'b0;

        // Reset with toggling input
        for (int i = 0; i < 3; i++) begin
            tick(i[0]);
            check_zero($sformatf("rst%0d", i));
        end

        // Lock at a 3-bit offset
        reset = 1'b0;
        start_track();
        tick(1'b1); tick(1'b0); tick(1'b1);
        repeat (4) send_byte(IDLE);
        check("lock_edge",      32'(first_active), 32'd35);
        check("lock_no_strobe", 32'(strobe_cnt),   32'd0);
        check("lock_active",    32'(active),       32'd1);

        // Data delivery, then a comma straddling two bytes is ignored
        exp_prev   = 8'h00;
        exp_prev_v = 1'b0;
        rx_byte_locked(8'hA5, "d0");
        rx_byte_locked(8'hBC, "d1");
        rx_byte_locked(8'h3C, "d2");
        rx_byte_locked(8'h0B, "st0");
        rx_byte_locked(8'hC0, "st1");
        check("st_active", 32'(active), 32'd1);

        // Aborted alignment, then normal lock
        reset = 1'b1;
        tick(1'b0);
        check_zero("rst2");
        reset = 1'b0;
        start_track();
        send_byte(IDLE);
        send_byte(IDLE);
        send_byte(8'h12);
        check("abort_active", 32'(active),       32'd0);
        check("abort_never",  32'(first_active), 32'hFFFF_FFFF);
        check("abort_strobe", 32'(strobe_cnt),   32'd0);
        repeat (4) send_byte(IDLE);
        check("relock_edge",   32'(first_active), 32'd56);
        check("relock_strobe", 32'(strobe_cnt),   32'd0);

        // Reset during bit 3 of a locked 0x5A byte
        exp_prev   = 8'h00;
        exp_prev_v = 1'b0;
        rx_byte_locked(8'hA5, "m0");
        tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
        reset = 1'b1;
        tick(1'b1);
        check_zero("mid_rst");
        reset = 1'b0;
        start_track();
        tick(1'b0); tick(1'b1); tick(1'b0);
        send_byte(8'h55);
        send_byte(8'h55);
        check("mid_no_lock",   32'(first_active), 32'hFFFF_FFFF);
        repeat (4) send_byte(IDLE);
        check("mid_relock",    32'(first_active), 32'd51);
        check("mid_no_strobe", 32'(strobe_cnt),   32'd0);

        // Serializer-style stream: data bytes with idle gaps
        exp_prev   = 8'h00;
        exp_prev_v = 1'b0;
        rx_byte_locked(8'h01, "lb0");
        rx_byte_locked(IDLE,  "lb1");
        rx_byte_locked(8'h02, "lb2");
        rx_byte_locked(IDLE,  "lb3");
        rx_byte_locked(8'h03, "lb4");
        rx_byte_locked(IDLE,  "lb5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_to_par_rx.md
Name: serial_to_par_rx

Overview:
- Receive-side counterpart of the lane serializer: single-lane serial bit stream in, 8-bit bytes out.
- Bytes arrive MSB first; idle bytes are IDLE (0xBC).
- Hunts for the IDLE comma at any bit offset, locks the byte boundary after LOCK_CNT consecutive aligned IDLE bytes, then delivers one byte per 8 bit-clocks.
- Sits in the phy receive path, feeding the byte un-striping logic.

Parameters:
- IDLE, 8'hBC, comma/idle byte used for alignment and marked not-valid on output.
- LOCK_CNT, 4, consecutive aligned IDLE bytes needed to declare lock; legal range 2..15.

Ports:
- clk_8f  input  1  bit clock; only clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial bit, sampled every rising clk_8f.
- data_out  output  8  last received byte; held for 8 cycles until the next boundary.
- valid_out  output  1  1 when data_out is a non-IDLE byte; held with data_out.
- byte_strobe  output  1  one-cycle pulse marking each new data_out update while locked.
- active  output  1  1 while in LOCKED.

Behaviour:
Reset:
- While reset=1 at a rising edge: state=HUNT, shift register=0, bit_cnt=0, idle_cnt=0.
- data_out=8'h00, valid_out=0, byte_strobe=0, active=0.

Datapath:
- Every non-reset edge: sr <= {sr[6:0], data_in}. Define nxt = {sr[6:0], data_in}.
- The first serial bit of a byte ends up in bit 7.
- bit_cnt is 3-bit, wraps 7->0. A byte boundary is the edge where bit_cnt==7 in ALIGN or LOCKED.

HUNT:
- Checked every edge. If nxt==IDLE: go to ALIGN, bit_cnt<=0, idle_cnt<=1.
- Otherwise stay in HUNT. bit_cnt is not used.

ALIGN:
- bit_cnt increments every edge.
- At a boundary with nxt==IDLE: idle_cnt++. If idle_cnt+1==LOCK_CNT: go to LOCKED, active<=1.
- At a boundary with nxt!=IDLE: go to HUNT, idle_cnt<=0.
- No byte_strobe and no data_out update in ALIGN.
- The boundary edge that completes lock does NOT itself produce a byte_strobe.

LOCKED:
- bit_cnt increments every edge.
- At each boundary: data_out<=nxt, valid_out<=(nxt!=IDLE), byte_strobe<=1.
- All other edges: byte_strobe<=0.
- Latency: data_out/valid_out are registered on the edge that samples bit 0 (LSB) of a byte. byte_strobe is high during the following cycle.
- LOCKED is left only by reset. No in-band loss-of-lock detection.

Boundary conditions:
- IDLE pattern straddling two data bytes in LOCKED: ignored, since only boundary bytes are checked.
- IDLE in HUNT at an arbitrary offset: accepted, alignment starts from that edge.
- Reset asserted mid-byte in any state: takes priority over all updates. Outputs clear on that edge, and relock needs LOCK_CNT fresh IDLE bytes.
- Stream with valid bytes and IDLE interleaved: every byte is strobed, and IDLE bytes carry valid_out=0.

Test Plan:
- Reset: reset=1 for 3 edges with data_in toggling -> data_out=00, valid_out=0, byte_strobe=0, active=0 throughout; on release, state is HUNT.
- Lock at offset: 3 junk bits 1,0,1, then 4×0xBC MSB first -> active rises on the edge sampling the LSB of the 4th 0xBC (edge 35 after reset release); byte_strobe stays 0 up to that edge.
- Data delivery: after lock, send 0xA5, 0xBC, 0x3C -> byte_strobe pulses every 8 edges. data_out/valid_out are A5/1, then BC/0, then 3C/1, each held 8 cycles.
- Aborted align: 0xBC, 0xBC, 0x12 -> returns to HUNT after 0x12 with active=0 and no strobes; a following 4×0xBC locks normally.
- Reset mid-operation: assert reset 1 cycle during bit 3 of a locked data byte -> outputs 0 on the next edge; 0x55 bytes after release give no strobe until 4×0xBC relock.
- Serializer loopback: drive from the lane serializer with valid_stripe toggling over bytes 01,02,03 -> the receiver reproduces 01,02,03 with valid_out=1, and idle gaps as BC with valid_out=0, in order with no lost bytes.
